// File: rtl/jailbreak_loader_pkg.sv
// Shared types and constants for the Jailbreak ROM loader.
package jailbreak_loader_pkg;

    // Loader lifecycle, from power-up through a verified ROM set.
    typedef enum logic [2:0] {
        IDLE,
        LOADING,
        CHECK,
        READY,
        ERROR
    } loader_state_t;

    // Bit positions in the one-hot rom_wr strobe.
    localparam int REG_MAIN = 0;
    localparam int REG_CHAR = 1;
    localparam int REG_SPR  = 2;
    localparam int REG_VLM  = 3;
    localparam int REG_PROM = 4;

    // ioctl_index values the loader responds to.
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/jailbreak_region_decode.sv
// Maps a download byte address onto one of the five ROM regions.
module jailbreak_region_decode
    import jailbreak_loader_pkg::*;
#(
    parameter logic [31:0] MAIN_SIZE = 32'h10000,
    parameter logic [31:0] CHAR_SIZE = 32'h08000,
    parameter logic [31:0] SPR_SIZE  = 32'h10000,
    parameter logic [31:0] VLM_SIZE  = 32'h02000,
    parameter logic [31:0] PROM_SIZE = 32'h00220
) (
    input  logic [24:0] addr,
    output logic [4:0]  region,
    output logic [16:0] rel_addr,
    output logic        in_range
);

    localparam logic [31:0] BASE_CHAR = MAIN_SIZE;
    localparam logic [31:0] BASE_SPR  = BASE_CHAR + CHAR_SIZE;
    localparam logic [31:0] BASE_VLM  = BASE_SPR + SPR_SIZE;
    localparam logic [31:0] BASE_PROM = BASE_VLM + VLM_SIZE;
    localparam logic [31:0] TOTAL     = BASE_PROM + PROM_SIZE;

    logic [31:0] addr_wide;
    logic [24:0] base;

    assign addr_wide = {7'd0, addr};

    // Pick the region whose span contains the address and subtract its base.
    always_comb begin
        region   = '0;
        base     = '0;
        in_range = 1'b1;
        if (addr_wide < BASE_CHAR) begin
            region[REG_MAIN] = 1'b1;
        end else if (addr_wide < BASE_SPR) begin
            region[REG_CHAR] = 1'b1;
            base             = BASE_CHAR[24:0];
        end else if (addr_wide < BASE_VLM) begin
            region[REG_SPR] = 1'b1;
            base            = BASE_SPR[24:0];
        end else if (addr_wide < BASE_PROM) begin
            region[REG_VLM] = 1'b1;
            base            = BASE_VLM[24:0];
        end else if (addr_wide < TOTAL) begin
            region[REG_PROM] = 1'b1;
            base             = BASE_PROM[24:0];
        end else begin
            in_range = 1'b0;
        end
        rel_addr = 17'(addr - base);
    end

endmodule

// File: rtl/jailbreak_rom_loader.sv
// Routes the HPS ioctl stream into the Jailbreak ROM regions and DIP bytes,
// holding the core in reset until a complete, correctly sized set has loaded.
module jailbreak_rom_loader
    import jailbreak_loader_pkg::*;
#(
    parameter logic [31:0] MAIN_SIZE = 32'h10000,
    parameter logic [31:0] CHAR_SIZE = 32'h08000,
    parameter logic [31:0] SPR_SIZE  = 32'h10000,
    parameter logic [31:0] VLM_SIZE  = 32'h02000,
    parameter logic [31:0] PROM_SIZE = 32'h00220
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [4:0]  rom_wr,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [23:0] dipsw,
    output logic        core_reset_n,
    output logic        load_error
);

    localparam logic [31:0] TOTAL       = MAIN_SIZE + CHAR_SIZE + SPR_SIZE + VLM_SIZE + PROM_SIZE;
    localparam logic [17:0] TOTAL_COUNT = TOTAL[17:0];
    localparam logic [17:0] COUNT_MAX   = '1;

    loader_state_t state, state_next;

    logic        dl_q, dl_prev;
    logic [7:0]  idx_q;
    logic        wr_q;
    logic [24:0] addr_q;
    logic [7:0]  dout_q;

    logic [4:0]  dec_region;
    logic [16:0] dec_rel_addr;
    logic        dec_in_range;

    logic [17:0] byte_count;
    logic        overflow;

    logic dl_rise, dl_fall, rom_req, dip_req, accept, overrun, load_start;

    jailbreak_region_decode #(
        .MAIN_SIZE (MAIN_SIZE),
        .CHAR_SIZE (CHAR_SIZE),
        .SPR_SIZE  (SPR_SIZE),
        .VLM_SIZE  (VLM_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_decode (
        .addr     (addr_q),
        .region   (dec_region),
        .rel_addr (dec_rel_addr),
        .in_range (dec_in_range)
    );

    assign dl_rise    = dl_q & ~dl_prev;
    assign dl_fall    = ~dl_q & dl_prev;
    assign rom_req    = wr_q && (idx_q == IDX_ROM);
    assign dip_req    = wr_q && (idx_q == IDX_DIP) && (addr_q[24:3] == '0) && (addr_q[2:0] < 3'd3);
    assign accept     = (state == LOADING) && rom_req && dec_in_range;
    assign overrun    = (state == LOADING) && rom_req && !dec_in_range;
    assign load_start = (state_next == LOADING) && (state != LOADING);

    // Input register stage; the download flag resets high so a transfer still
    // running when reset lifts does not look like a fresh start.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            dl_q    <= 1'b1;
            dl_prev <= 1'b1;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            dl_q    <= ioctl_download;
            dl_prev <= dl_q;
            idx_q   <= ioctl_index;
            wr_q    <= ioctl_wr;
            addr_q  <= ioctl_addr;
            dout_q  <= ioctl_dout;
        end
    end

    // Loader state register.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a ROM download start always restarts loading.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, READY, ERROR: begin
                if (dl_rise && (idx_q == IDX_ROM)) begin
                    state_next = LOADING;
                end
            end
            LOADING: begin
                if (dl_fall) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if ((byte_count == TOTAL_COUNT) && !overflow) begin
                    state_next = READY;
                end else begin
                    state_next = ERROR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Count accepted bytes and remember any write past the end of the set.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else if (load_start) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept && (byte_count != COUNT_MAX)) begin
                byte_count <= byte_count + 18'd1;
            end
            if (overrun) begin
                overflow <= 1'b1;
            end
        end
    end

    // DIP bytes are accepted in any state and never touch the ROM side.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            dipsw <= 24'hFFFFFF;
        end else if (dip_req) begin
            unique case (addr_q[1:0])
                2'd0:    dipsw[7:0]   <= dout_q;
                2'd1:    dipsw[15:8]  <= dout_q;
                default: dipsw[23:16] <= dout_q;
            endcase
        end
    end

    // ROM write port: one-cycle strobe, address and data held until the next byte.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            rom_wr   <= '0;
            rom_addr <= '0;
            rom_data <= '0;
        end else begin
            rom_wr <= accept ? dec_region : 5'd0;
            if (accept) begin
                rom_addr <= dec_rel_addr;
                rom_data <= dout_q;
            end
        end
    end

    assign core_reset_n = (state == READY);
    assign load_error   = (state == ERROR);

endmodule

// File: doc/jailbreak_rom_loader.md
# jailbreak_rom_loader

Upstream of the Jailbreak core. Consumes the HPS ioctl download stream and routes each ROM byte to one of five core ROM regions as a region-relative write. Captures the DIP bytes and holds the core in reset until a complete, correctly sized ROM set has arrived. The core's ROM/DIP ports are fed only through this block; the core never decodes ioctl traffic itself.

## Interface
Parameters:
- MAIN_SIZE, 32'h10000: main CPU ROM bytes (region 0)
- CHAR_SIZE, 32'h08000: tile ROM bytes (region 1)
- SPR_SIZE, 32'h10000: sprite ROM bytes (region 2)
- VLM_SIZE, 32'h02000: speech ROM bytes (region 3)
- PROM_SIZE, 32'h00220: colour/lookup PROM bytes (region 4)

Ports:
- clk_49m  in  1  system clock, 49.152 MHz
- reset  in  1  asynchronous, active-low
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  0 = ROM set, 254 = DIP bytes, other values ignored
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address within the download
- ioctl_dout  in  8  byte data
- rom_wr  out  5  one-hot region write strobe
- rom_addr  out  17  region-relative byte address
- rom_data  out  8  byte to write
- dipsw  out  24  {dip_sw[2], dip_sw[1], dip_sw[0]}, raw active-low bytes
- core_reset_n  out  1  0 holds the core in reset
- load_error  out  1  last ROM download was short or overflowed

## Operation
- Regions are contiguous from address 0, in order 0..4. Each base is the sum of the preceding sizes. TOTAL = sum of all five sizes (0x2A220 by default).
- FSM states:
  - IDLE: after reset, nothing loaded.
  - LOADING: ROM download in progress.
  - CHECK: one cycle, compares the byte count with TOTAL.
  - READY
  - ERROR
- Transitions:
  - IDLE, READY or ERROR -> LOADING on the rising edge of ioctl_download with ioctl_index==0.
  - LOADING -> CHECK on the falling edge of ioctl_download.
  - CHECK -> READY if byte_count==TOTAL and no overflow; otherwise CHECK -> ERROR.
- Entering LOADING clears byte_count, the overflow flag and load_error, and drives core_reset_n=0.
- In LOADING, ioctl_wr with index 0 and addr<TOTAL:
  - One rom_wr bit pulses, with rom_addr = addr − region base and rom_data = dout.
  - byte_count increments, saturating at 2^18−1.
- In LOADING, ioctl_wr with index 0 and addr>=TOTAL: no strobe; the overflow flag is set.
- DIP writes (index 254, addr[24:3]==0, addr[2:0]<3) update dipsw byte addr[2:0] in any state. They produce no rom_wr and do not affect the FSM. DIP writes with addr[2:0] of 3..7 are ignored.
- core_reset_n is 1 only in READY. load_error is 1 only in ERROR.
- ioctl_wr with any other index, or ioctl_wr outside LOADING with index 0, is ignored.

## Timing
- Reset values:
  - state = IDLE
  - rom_wr = 0
  - rom_addr = 0
  - rom_data = 0
  - dipsw = 24'hFFFFFF
  - core_reset_n = 0
  - load_error = 0
- Inputs are registered once. rom_wr/rom_addr/rom_data are valid exactly 2 cycles after the ioctl_wr cycle. rom_addr and rom_data are held stable until the next accepted write.
- rom_wr is a single-cycle pulse per accepted byte. Back-to-back ioctl_wr on consecutive cycles gives consecutive strobes with no drops.
- The download falling edge is detected on the registered signal. CHECK occurs 2 cycles after the falling edge; the READY/ERROR outputs change the cycle after that.
- If a write and the falling edge arrive in the same cycle, the write is counted before CHECK.
- Asserting reset mid-download: everything returns to reset values immediately, and any partially loaded data is treated as absent. A new download is then required.
- The sizes of all five regions must be at most 2^17 bytes. Address subtraction is done at 25 bits and truncated to 17 bits.

## Structure
- Package jailbreak_loader_pkg holds:
  - the state enum (IDLE, LOADING, CHECK, READY, ERROR)
  - the region index constants REG_MAIN..REG_PROM
  - the ioctl index constants IDX_ROM=0 and IDX_DIP=254
- Sub-module jailbreak_region_decode: combinational. Input is addr[24:0]; outputs are the one-hot region (5 bits), the relative address (17 bits) and an in_range flag. It is parameterized by the five sizes.
- The top level contains the input register stage, the edge detectors, the FSM, the byte counter, the DIP registers and the output registers.

## Test plan
- Full load: download 0x2A220 bytes, data = addr[7:0].
  - Byte 0x10000 -> rom_wr=00010, rom_addr=0, data 0x00.
  - Byte 0x29FFF -> rom_wr=01000, rom_addr=0x1FFF.
  - After the falling edge, core_reset_n=1 and load_error=0.
- Short load: 0x2A21F bytes -> ERROR, load_error=1, core_reset_n=0.
- Overflow: a full set plus a write at addr 0x2A220 -> no strobe for that write; ERROR at the end of the download.
- DIP: index 254 writes 0x5A at addr 0, 0xC3 at addr 2, and a write at addr 5 -> dipsw=24'hC3FF5A in both IDLE and READY. rom_wr stays 0 throughout.
- Reload and reset:
  - From READY, a new download start drops core_reset_n within 2 cycles.
  - reset asserted after 100 bytes -> all outputs at reset values and dipsw=24'hFFFFFF.
- Back-to-back: 16 consecutive-cycle writes -> 16 strobes with contiguous rom_addr, none dropped.
